irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 The block SHALL have parameter NSRC, default 6, number of interrupt sources; equals the HWInt width of the coprocessor.
REQ-002 The block SHALL have the following ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- src  in  NSRC  raw interrupt lines, synchronous to clk.
- bus_addr  in  2  register select: 0=MASK, 1=MODE, 2=PEND, 3=STAT.
- bus_we  in  1  register write strobe.
- bus_wdata  in  32  write data.
- bus_rdata  out  32  read data, combinational from bus_addr.
- int_ack  in  1  one-cycle pulse; the CPU has taken the interrupt.
- eret  in  1  one-cycle pulse; the handler has returned (EXL cleared).
- hwint  out  NSRC  registered one-hot request toward the coprocessor HWInt input.
- busy  out  1  registered; high in states REQ and SERVICE.

Function
REQ-003 Register MASK[NSRC-1:0] SHALL enable each source (1=enabled); R/W.
REQ-004 Register MODE[NSRC-1:0] SHALL select the trigger type per source (1=rising edge, 0=level); R/W.
REQ-005 Register PEND[NSRC-1:0] SHALL track pending sources.
- Level source: PEND bit equals src bit of the previous cycle.
- Edge source: PEND bit sets when src rises (prev 0, now 1) and stays set until cleared.
REQ-006 A write to PEND SHALL be write-1-to-clear, and SHALL affect edge sources only.
REQ-007 If a set event and a clear (by write or by ack) hit the same edge PEND bit in one cycle, the set SHALL win.
REQ-008 Register STAT SHALL read as {24'b0, state[1:0], 3'b0, id[2:0]}.
- id is the source in service or being requested.
- state encoding: IDLE=0, REQ=1, SERVICE=2.
REQ-009 Unused upper bits SHALL read 0; reads of MASK, MODE and PEND SHALL return zero-extended values.
REQ-010 Arbitration SHALL be fixed priority: the lowest-index bit of (PEND & MASK) wins.
REQ-011 FSM IDLE: if (PEND & MASK) != 0, the block SHALL latch the winner into id and go to REQ.
- hwint = one-hot(id) from the next cycle, i.e. a 1-cycle latency from PEND to hwint.
REQ-012 FSM REQ: hwint SHALL hold one-hot(id) and id SHALL NOT change, even if a higher-priority source becomes pending.
REQ-013 REQ, on int_ack: the block SHALL go to SERVICE, clear hwint, and clear PEND[id] if MODE[id]=1 (subject to REQ-007).
REQ-014 REQ, no int_ack, and PEND[id]&MASK[id] now 0 (level source dropped, masked, or W1C): the block SHALL return to IDLE and clear hwint (spurious request withdrawn).
REQ-015 If int_ack and withdrawal coincide in REQ, int_ack SHALL take precedence.
REQ-016 FSM SERVICE: hwint SHALL be 0 (no nesting); PEND SHALL keep accumulating.
- On eret, the block SHALL go to IDLE; re-arbitration starts the cycle after.
REQ-017 int_ack in IDLE or SERVICE, and eret in IDLE or REQ, SHALL be ignored.
REQ-018 A MASK or MODE write SHALL take effect on the next cycle's arbitration.
- A MODE change from level to edge SHALL leave PEND as is.
REQ-019 The encoding 3 of state is illegal; if reached, the block SHALL go to IDLE and clear hwint.

Reset
REQ-020 On reset, MASK, MODE, PEND, id and the src history register SHALL be 0, the state SHALL be IDLE, and hwint and busy SHALL be 0.
REQ-021 Reset SHALL take priority over every other input.
REQ-022 Reset asserted in REQ or SERVICE SHALL abandon the request, with hwint=0 on the cycle after reset.

Verification
REQ-023 Edge basic: MASK=0x3F, MODE=0x3F; src[2] pulses 1 cycle.
- PEND=0x04 next cycle; hwint=0x04 one cycle later.
- int_ack -> hwint=0, PEND=0, STAT=0x82.
- eret -> STAT=0x02 (state IDLE).
REQ-024 Priority: MASK=0x3F, MODE=0x3F; src[5] and src[1] rise in the same cycle.
- hwint=0x02 first; ack, eret -> hwint=0x20.
REQ-025 Withdrawal: MODE=0 (level), MASK=0x01; src[0] high 2 cycles then low, no ack.
- hwint=0x01 for 1-2 cycles, then 0; state returns to IDLE.
REQ-026 Set wins over clear: edge source 3 rises in the same cycle as a PEND write of 0x08.
- PEND reads 0x08 afterwards.
REQ-027 No nesting: in SERVICE for source 4, source 0 rises.
- hwint stays 0 until eret; then hwint=0x01.
REQ-028 Reset mid-REQ: hwint=0x10; assert reset 1 cycle.
- hwint=0, busy=0, PEND=0, STAT=0 next cycle.

Source files
------------

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source mask/mode, pending tracking and
// fixed-priority one-hot request toward the coprocessor HWInt input.
module irq_ctrl #(
  parameter int NSRC = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic [1:0]      bus_addr,
  input  logic            bus_we,
  input  logic [31:0]     bus_wdata,
  output logic [31:0]     bus_rdata,
  input  logic            int_ack,
  input  logic            eret,
  output logic [NSRC-1:0] hwint,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2,
    ILLEGAL = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      id_q, id_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] mode_q, mode_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] hwint_q, hwint_d;
  logic            busy_q, busy_d;

  logic [NSRC-1:0] req;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] clr;
  logic [NSRC-1:0] one;
  logic [2:0]      win;
  logic            wr_mask, wr_mode, wr_pend;
  logic            unused_wdata;

  assign unused_wdata = ^bus_wdata[31:NSRC];
  assign one          = {{(NSRC-1){1'b0}}, 1'b1};
  assign req          = pend_q & mask_q;
  assign rise         = src & ~src_q;
  assign wr_mask      = bus_we && (bus_addr == 2'd0);
  assign wr_mode      = bus_we && (bus_addr == 2'd1);
  assign wr_pend      = bus_we && (bus_addr == 2'd2);

  always_comb begin
    win = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) win = 3'(i);
    end
  end

  always_comb begin
    mask_d = wr_mask ? bus_wdata[NSRC-1:0] : mask_q;
    mode_d = wr_mode ? bus_wdata[NSRC-1:0] : mode_q;
    clr = '0;
    if (wr_pend) clr = bus_wdata[NSRC-1:0];
    if (state_q == REQ && int_ack) clr = clr | (one << id_q);
    clr = clr & mode_q;
    // Level bits mirror src one cycle late; edge bits are sticky, set wins
    pend_d = (mode_q & (rise | (pend_q & ~clr))) | (~mode_q & src);
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = REQ;
          id_d    = win;
        end
      end
      REQ: begin
        if (int_ack)          state_d = SERVICE;
        else if (!req[id_q])  state_d = IDLE;
      end
      SERVICE: begin
        if (eret) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    hwint_d = (state_d == REQ) ? (one << id_d) : '0;
    busy_d  = (state_d == REQ) || (state_d == SERVICE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      id_q    <= '0;
      mask_q  <= '0;
      mode_q  <= '0;
      pend_q  <= '0;
      src_q   <= '0;
      hwint_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      src_q   <= src;
      hwint_q <= hwint_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    bus_rdata = '0;
    unique case (bus_addr)
      2'd0: bus_rdata[NSRC-1:0] = mask_q;
      2'd1: bus_rdata[NSRC-1:0] = mode_q;
      2'd2: bus_rdata[NSRC-1:0] = pend_q;
      default: bus_rdata = {24'b0, state_q, 3'b0, id_q};
    endcase
  end

  assign hwint = hwint_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  src;
  logic [1:0]  bus_addr;
  logic        bus_we;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        int_ack;
  logic        eret;
  logic [5:0]  hwint;
  logic        busy;

  int checks = 0;
  int failures = 0;

  irq_ctrl #(.NSRC(6)) dut (
    .clk(clk), .reset(reset), .src(src),
    .bus_addr(bus_addr), .bus_we(bus_we),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .int_ack(int_ack), .eret(eret),
    .hwint(hwint), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus_addr = a; bus_wdata = d; bus_we = 1'b1;
    step();
    bus_we = 1'b0; bus_wdata = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus_addr = a;
    #1;
    d = bus_rdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      checks++;
      if (d !== 32'h0) begin
        failures++;
        $display("FAIL reset_reg%0d got=%h exp=0", a, d);
      end
    end
    checks++;
    if (hwint !== 6'h0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_out hwint=%h busy=%b exp 0/0", hwint, busy);
    end
  endtask

  task automatic test_edge_basic();
    logic [31:0] d;
    wr(2'd0, 32'h3F);
    wr(2'd1, 32'h3F);
    rd(2'd0, d);
    checks++;
    if (d !== 32'h3F) begin failures++; $display("FAIL mask_rb got=%h exp=3f", d); end
    src = 6'h04; step(); src = 6'h00;
    rd(2'd2, d);
    checks++;
    if (d !== 32'h04 || hwint !== 6'h0) begin
      failures++; $display("FAIL edge_pend pend=%h hwint=%h exp 04/00", d, hwint);
    end
    step();
    checks++;
    if (hwint !== 6'h04 || busy !== 1'b1) begin
      failures++; $display("FAIL edge_hwint hwint=%h busy=%b exp 04/1", hwint, busy);
    end
    eret = 1'b1; step(); eret = 1'b0;
    checks++;
    if (hwint !== 6'h04) begin failures++; $display("FAIL eret_in_req hwint=%h exp=04", hwint); end
    int_ack = 1'b1; step(); int_ack = 1'b0;
    rd(2'd2, d);
    checks++;
    if (hwint !== 6'h0 || d !== 32'h0) begin
      failures++; $display("FAIL edge_ack hwint=%h pend=%h exp 00/00", hwint, d);
    end
    rd(2'd3, d);
    checks++;
    if (d !== 32'h82) begin failures++; $display("FAIL edge_stat_svc got=%h exp=82", d); end
    eret = 1'b1; step(); eret = 1'b0;
    rd(2'd3, d);
    checks++;
    if (d !== 32'h02 || busy !== 1'b0) begin
      failures++; $display("FAIL edge_stat_idle stat=%h busy=%b exp 02/0", d, busy);
    end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    src = 6'h22; step(); src = 6'h00;
    step();
    checks++;
    if (hwint !== 6'h02) begin failures++; $display("FAIL prio_first hwint=%h exp=02", hwint); end
    int_ack = 1'b1; step(); int_ack = 1'b0;
    rd(2'd2, d);
    checks++;
    if (d !== 32'h20) begin failures++; $display("FAIL prio_pend got=%h exp=20", d); end
    eret = 1'b1; step(); eret = 1'b0;
    checks++;
    if (hwint !== 6'h0) begin failures++; $display("FAIL prio_gap hwint=%h exp=00", hwint); end
    step();
    checks++;
    if (hwint !== 6'h20) begin failures++; $display("FAIL prio_second hwint=%h exp=20", hwint); end
    int_ack = 1'b1; step(); int_ack = 1'b0;
    eret = 1'b1; step(); eret = 1'b0;
  endtask

  task automatic test_withdraw();
    logic [31:0] d;
    wr(2'd1, 32'h00);
    wr(2'd0, 32'h01);
    src = 6'h01; step(); step(); src = 6'h00;
    checks++;
    if (hwint !== 6'h01) begin failures++; $display("FAIL wd_c1 hwint=%h exp=01", hwint); end
    step();
    checks++;
    if (hwint !== 6'h01) begin failures++; $display("FAIL wd_c2 hwint=%h exp=01", hwint); end
    step();
    rd(2'd3, d);
    checks++;
    if (hwint !== 6'h0 || d !== 32'h0 || busy !== 1'b0) begin
      failures++; $display("FAIL wd_idle hwint=%h stat=%h busy=%b exp 00/00/0", hwint, d, busy);
    end
  endtask

  task automatic test_set_wins();
    logic [31:0] d;
    wr(2'd0, 32'h00);
    wr(2'd1, 32'h3F);
    src = 6'h08;
    wr(2'd2, 32'h08);
    rd(2'd2, d);
    checks++;
    if (d !== 32'h08) begin failures++; $display("FAIL set_wins pend=%h exp=08", d); end
    wr(2'd2, 32'h08);
    src = 6'h00;
    rd(2'd2, d);
    checks++;
    if (d !== 32'h00) begin failures++; $display("FAIL w1c pend=%h exp=00", d); end
  endtask

  task automatic test_no_nesting();
    logic [31:0] d;
    wr(2'd0, 32'h3F);
    src = 6'h10; step(); src = 6'h00;
    step();
    checks++;
    if (hwint !== 6'h10) begin failures++; $display("FAIL nest_req hwint=%h exp=10", hwint); end
    int_ack = 1'b1; step(); int_ack = 1'b0;
    rd(2'd3, d);
    checks++;
    if (d !== 32'h84) begin failures++; $display("FAIL nest_stat got=%h exp=84", d); end
    src = 6'h01; step(); src = 6'h00;
    rd(2'd2, d);
    checks++;
    if (hwint !== 6'h0 || d !== 32'h01) begin
      failures++; $display("FAIL nest_svc hwint=%h pend=%h exp 00/01", hwint, d);
    end
    int_ack = 1'b1; step(); int_ack = 1'b0;
    checks++;
    if (hwint !== 6'h0) begin failures++; $display("FAIL nest_ack_svc hwint=%h exp=00", hwint); end
    eret = 1'b1; step(); eret = 1'b0;
    checks++;
    if (hwint !== 6'h0) begin failures++; $display("FAIL nest_eret hwint=%h exp=00", hwint); end
    step();
    checks++;
    if (hwint !== 6'h01) begin failures++; $display("FAIL nest_after hwint=%h exp=01", hwint); end
    int_ack = 1'b1; step(); int_ack = 1'b0;
    eret = 1'b1; step(); eret = 1'b0;
  endtask

  task automatic test_reset_mid_req();
    logic [31:0] d;
    src = 6'h10; step(); src = 6'h00;
    step();
    checks++;
    if (hwint !== 6'h10 || busy !== 1'b1) begin
      failures++; $display("FAIL rst_pre hwint=%h busy=%b exp 10/1", hwint, busy);
    end
    reset = 1'b1; step(); reset = 1'b0;
    checks++;
    if (hwint !== 6'h0 || busy !== 1'b0) begin
      failures++; $display("FAIL rst_out hwint=%h busy=%b exp 00/0", hwint, busy);
    end
    rd(2'd2, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL rst_pend got=%h exp=0", d); end
    rd(2'd3, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL rst_stat got=%h exp=0", d); end
    rd(2'd0, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL rst_mask got=%h exp=0", d); end
  endtask

  initial begin
    reset = 1'b1; src = '0; bus_addr = '0; bus_we = 1'b0;
    bus_wdata = '0; int_ack = 1'b0; eret = 1'b0;
    test_reset();
    test_edge_basic();
    test_priority();
    test_withdraw();
    test_set_wins();
    test_no_nesting();
    test_reset_mid_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
